hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter BR_PENALTY, default 2, branch fetch-squash cycles; legal range 1..7.
REQ-003 Parameter CNT_W, default 32, width of the performance counters.
REQ-004 clk  input  1  rising-edge clock; one clock; reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ID_rs1, ID_rs2  input  REG_ADDR_W each  source registers in ID.
REQ-007 ID_rs1_used, ID_rs2_used  input  1 each  source actually read.
REQ-008 ID_br_sel  input  3  branch select from decode; `DONT_BRANCH means not a branch.
REQ-009 ID_EX_rd, EX_MEM_rd  input  REG_ADDR_W each  destinations in EX and MEM.
REQ-010 ID_EX_wr_en, EX_MEM_wr_en, ID_EX_is_load  input  1 each  writeback and load flags.
REQ-011 mem_busy  input  1  data memory not ready.
REQ-012 ST_pc_en, ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en  output  1 each  stage enables.
REQ-013 ST_br_stall  output  1  IF/ID loads a bubble.
REQ-014 ST_id_ex_bubble  output  1  ID/EX loads a NOP.
REQ-015 ST_stall_cycles, ST_br_cycles  output  CNT_W each  data-stall and branch-stall counts.

Function
REQ-016 Hazard match: producer wr_en=1, rd!=0, and rd equals a source that has its used flag set.
REQ-017 Priority, highest first: mem_busy, data hazard, branch, none.
REQ-018 mem_busy=1: all five enables 0, br_stall 0, bubble 0; FSM state, branch counter and perf counters hold.
REQ-019 Data hazard: pc_en=0, if_id_en=0, id_ex_bubble=1, other enables 1, ST_stall_cycles +1.
REQ-020 A branch blocked by a data hazard does not start its penalty until the hazard clears.
REQ-021 FSM states: RUN and BR_WAIT, plus a 3-bit down-counter br_cnt.
REQ-022 In RUN, with ID_br_sel!=`DONT_BRANCH and no higher-priority event, the same cycle drives:
 - ST_br_stall=1, all enables 1;
 - if BR_PENALTY>1: go to BR_WAIT with br_cnt=BR_PENALTY-1, otherwise stay in RUN.
REQ-023 In BR_WAIT: ST_br_stall=1, all enables 1, br_cnt decrements, return to RUN when br_cnt reaches 1 at the edge.
REQ-024 In BR_WAIT, ID_br_sel and hazard inputs are ignored because ID holds a squashed slot.
REQ-025 Each cycle with ST_br_stall=1 increments ST_br_cycles.
REQ-026 Both perf counters saturate at all-ones and never wrap.
REQ-027 Branch stall is a total of BR_PENALTY cycles; BR_PENALTY=1 matches the single-cycle legacy behaviour.
REQ-028 No hazard, no branch, no mem_busy: all enables 1, br_stall 0, bubble 0.

Reset
REQ-029 rst=1 at the edge: state RUN, br_cnt=0, both counters 0; takes precedence over all inputs, including mid-BR_WAIT.
REQ-030 While rst=1: all enables 1, ST_br_stall 0, ST_id_ex_bubble 0.

Configuration
REQ-031 Macro HAZARD_FWD_EN defined: only a load in EX (ID_EX_is_load=1) matching ID creates a data hazard, giving a one-cycle stall; EX_MEM producers never stall.
REQ-032 HAZARD_FWD_EN undefined: any matching ID_EX or EX_MEM producer stalls until it leaves MEM; the register file is write-before-read.

Structure
REQ-033 `DONT_BRANCH and `TRUE come from sys_defs.vh; the FSM state typedef hz_state_t goes in shared package hazard_pkg.
REQ-034 Sub-module hazard_cmp performs one producer-vs-two-source match; instantiate it twice.

Verification
REQ-035 HAZARD_FWD_EN defined; load to x5 in EX, ID reads x5 with rs1_used=1 -> one cycle of pc_en=0, if_id_en=0, bubble=1; ST_stall_cycles=1.
REQ-036 HAZARD_FWD_EN undefined; ALU op to x7 in EX, ID reads x7 -> two stall cycles; ST_stall_cycles=2.
REQ-037 BR_PENALTY=3; branch in ID -> ST_br_stall=1 for exactly 3 cycles; ST_br_cycles=3.
REQ-038 Producer rd=0 with wr_en=1 matching ID_rs1=0 -> no stall.
REQ-039 Branch stall in progress; mem_busy for 4 cycles, then rst asserted 1 cycle after release -> during busy, enables 0 and br_cnt held; after rst, state RUN, counters 0.
REQ-040 Load-use hazard coinciding with a branch in ID -> stall for 1 cycle, then BR_PENALTY branch-stall cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types for the hazard unit: FSM state encoding and the
//               branch-select / boolean macros normally supplied by
//               sys_defs.vh (defined here only if not already present).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DONT_BRANCH
`define DONT_BRANCH 3'b000
`endif

`ifndef TRUE
`define TRUE 1'b1
`endif

package hazard_pkg;

  // Branch-stall FSM: RUN is normal flow, BR_WAIT burns the remaining
  // squash cycles after the first branch-stall cycle.
  typedef enum logic [0:0] {
    HZ_RUN     = 1'b0,
    HZ_BR_WAIT = 1'b1
  } hz_state_t;

  localparam int BR_CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/hazard_cmp.sv
// ============================================================================
// Module      : hazard_cmp
// Description : Compares one in-flight producer destination against the two
//               ID-stage source registers. Register 0 never matches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_cmp #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] prod_rd,
  input  logic                  prod_wr_en,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic                  match
);

  logic rd_valid;
  logic hit_rs1;
  logic hit_rs2;

  assign rd_valid = prod_wr_en && (prod_rd != '0);
  assign hit_rs1  = rs1_used && (rs1 == prod_rd);
  assign hit_rs2  = rs2_used && (rs2 == prod_rd);
  assign match    = rd_valid && (hit_rs1 || hit_rs2);

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard unit. Resolves memory-busy freezes, RAW data
//               hazards and multi-cycle branch fetch squashes, and keeps
//               saturating data-stall / branch-stall performance counters.
//               Optional macro HAZARD_FWD_EN: forwarding present, so only a
//               load in EX matching ID causes a (one-cycle) stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int BR_PENALTY = 2,   // legal 1..7
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_rs1_used,
  input  logic                  ID_rs2_used,
  input  logic [2:0]            ID_br_sel,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  input  logic                  ID_EX_wr_en,
  input  logic                  EX_MEM_wr_en,
  input  logic                  ID_EX_is_load,
  input  logic                  mem_busy,
  output logic                  ST_pc_en,
  output logic                  ST_if_id_en,
  output logic                  ST_id_ex_en,
  output logic                  ST_ex_mem_en,
  output logic                  ST_mem_wb_en,
  output logic                  ST_br_stall,
  output logic                  ST_id_ex_bubble,
  output logic [CNT_W-1:0]      ST_stall_cycles,
  output logic [CNT_W-1:0]      ST_br_cycles
);

  localparam logic [BR_CNT_W-1:0] BR_RELOAD = BR_CNT_W'(BR_PENALTY - 1);

  hz_state_t             state_q, state_d;
  logic [BR_CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]      br_cycles_q, br_cycles_d;

  logic ex_match;
  logic mem_match;
  logic data_haz;
  logic is_branch;

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_ex (
    .prod_rd    (ID_EX_rd),
    .prod_wr_en (ID_EX_wr_en),
    .rs1        (ID_rs1),
    .rs2        (ID_rs2),
    .rs1_used   (ID_rs1_used),
    .rs2_used   (ID_rs2_used),
    .match      (ex_match)
  );

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem (
    .prod_rd    (EX_MEM_rd),
    .prod_wr_en (EX_MEM_wr_en),
    .rs1        (ID_rs1),
    .rs2        (ID_rs2),
    .rs1_used   (ID_rs1_used),
    .rs2_used   (ID_rs2_used),
    .match      (mem_match)
  );

`ifdef HAZARD_FWD_EN
  // Forwarding covers ALU results from EX and everything in MEM; only a
  // load still in EX has no value yet.
  logic unused_mem_match;
  assign unused_mem_match = mem_match;
  assign data_haz         = ex_match && ID_EX_is_load;
`else
  // No forwarding: wait until the producer has left MEM; the write-before-
  // read register file covers the WB stage.
  logic unused_is_load;
  assign unused_is_load = ID_EX_is_load;
  assign data_haz       = ex_match || mem_match;
`endif

  assign is_branch = (ID_br_sel != `DONT_BRANCH);

  // Priority resolution, FSM next state and counter updates.
  always_comb begin
    state_d         = state_q;
    br_cnt_d        = br_cnt_q;
    stall_cycles_d  = stall_cycles_q;
    br_cycles_d     = br_cycles_q;
    ST_pc_en        = 1'b1;
    ST_if_id_en     = 1'b1;
    ST_id_ex_en     = 1'b1;
    ST_ex_mem_en    = 1'b1;
    ST_mem_wb_en    = 1'b1;
    ST_br_stall     = 1'b0;
    ST_id_ex_bubble = 1'b0;

    if (rst) begin
      // Outputs stay at their free-running values; the register block
      // applies the reset state.
    end else if (mem_busy) begin
      ST_pc_en     = 1'b0;
      ST_if_id_en  = 1'b0;
      ST_id_ex_en  = 1'b0;
      ST_ex_mem_en = 1'b0;
      ST_mem_wb_en = 1'b0;
    end else if (state_q == HZ_BR_WAIT) begin
      // ID holds a squashed slot, so its branch/hazard inputs are ignored.
      ST_br_stall = 1'b1;
      br_cnt_d    = br_cnt_q - BR_CNT_W'(1);
      if (br_cnt_q == BR_CNT_W'(1)) begin
        state_d = HZ_RUN;
      end
    end else if (data_haz) begin
      ST_pc_en        = 1'b0;
      ST_if_id_en     = 1'b0;
      ST_id_ex_bubble = 1'b1;
    end else if (is_branch) begin
      ST_br_stall = 1'b1;
      if (BR_PENALTY > 1) begin
        state_d  = HZ_BR_WAIT;
        br_cnt_d = BR_RELOAD;
      end
    end

    if (ST_id_ex_bubble && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (ST_br_stall && !(&br_cycles_q)) begin
      br_cycles_d = br_cycles_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HZ_RUN;
      br_cnt_q       <= '0;
      stall_cycles_q <= '0;
      br_cycles_q    <= '0;
    end else begin
      state_q        <= state_d;
      br_cnt_q       <= br_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      br_cycles_q    <= br_cycles_d;
    end
  end

  assign ST_stall_cycles = stall_cycles_q;
  assign ST_br_cycles    = br_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit (BR_PENALTY=3, CNT_W=4).
//               Expected per-cycle outputs are queued as stimulus is applied
//               and compared on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int RW  = 5;
  localparam int BRP = 3;
  localparam int CW  = 4;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_TAKE = 3'b001;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_HAZ  = 5'b00111;
  localparam logic [4:0] EN_NONE = 5'b00000;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] ID_rs1, ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic          ID_rs1_used, ID_rs2_used;
  logic [2:0]    ID_br_sel;
  logic          ID_EX_wr_en, EX_MEM_wr_en, ID_EX_is_load, mem_busy;
  logic          ST_pc_en, ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en;
  logic          ST_br_stall, ST_id_ex_bubble;
  logic [CW-1:0] ST_stall_cycles, ST_br_cycles;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(RW), .BR_PENALTY(BRP), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_rs1_used     (ID_rs1_used),
    .ID_rs2_used     (ID_rs2_used),
    .ID_br_sel       (ID_br_sel),
    .ID_EX_rd        (ID_EX_rd),
    .EX_MEM_rd       (EX_MEM_rd),
    .ID_EX_wr_en     (ID_EX_wr_en),
    .EX_MEM_wr_en    (EX_MEM_wr_en),
    .ID_EX_is_load   (ID_EX_is_load),
    .mem_busy        (mem_busy),
    .ST_pc_en        (ST_pc_en),
    .ST_if_id_en     (ST_if_id_en),
    .ST_id_ex_en     (ST_id_ex_en),
    .ST_ex_mem_en    (ST_ex_mem_en),
    .ST_mem_wb_en    (ST_mem_wb_en),
    .ST_br_stall     (ST_br_stall),
    .ST_id_ex_bubble (ST_id_ex_bubble),
    .ST_stall_cycles (ST_stall_cycles),
    .ST_br_cycles    (ST_br_cycles)
  );

  typedef struct packed {
    logic [4:0]    en;
    logic          brs;
    logic          bub;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            total = 0;
  int            bad   = 0;
  string         cur   = "init";
  logic [CW-1:0] exp_sc;
  logic [CW-1:0] exp_bc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare queued expectations against the settled outputs mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk({cur, ".en"},  32'({ST_pc_en, ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en}), 32'(mon_e.en));
      chk({cur, ".brs"}, 32'(ST_br_stall),     32'(mon_e.brs));
      chk({cur, ".bub"}, 32'(ST_id_ex_bubble), 32'(mon_e.bub));
      chk({cur, ".sc"},  32'(ST_stall_cycles), 32'(mon_e.sc));
      chk({cur, ".bc"},  32'(ST_br_cycles),    32'(mon_e.bc));
    end
  end

  task automatic clr();
    ID_rs1 = '0; ID_rs2 = '0; ID_rs1_used = 1'b0; ID_rs2_used = 1'b0;
    ID_br_sel = BR_NONE;
    ID_EX_rd = '0; EX_MEM_rd = '0;
    ID_EX_wr_en = 1'b0; EX_MEM_wr_en = 1'b0; ID_EX_is_load = 1'b0;
    mem_busy = 1'b0;
  endtask

  // One clock: queue the expected outputs, advance, update counter model.
  task automatic step(input logic [4:0] en, input logic brs, input logic bub);
    exp_t e;
    e.en = en; e.brs = brs; e.bub = bub; e.sc = exp_sc; e.bc = exp_bc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_sc = '0;
      exp_bc = '0;
    end else begin
      if (bub && exp_sc != '1) exp_sc = exp_sc + 1'b1;
      if (brs && exp_bc != '1) exp_bc = exp_bc + 1'b1;
    end
  endtask

  task automatic run_c();  step(EN_ALL,  1'b0, 1'b0); endtask
  task automatic haz_c();  step(EN_HAZ,  1'b0, 1'b1); endtask
  task automatic br_c();   step(EN_ALL,  1'b1, 1'b0); endtask
  task automatic busy_c(); step(EN_NONE, 1'b0, 1'b0); endtask

  // Load (or ALU op when is_load=0) to x5 in EX, ID reads x5 via rs1.
  task automatic ld_x5_in_ex(input logic is_load);
    ID_EX_rd = 5'd5; ID_EX_wr_en = 1'b1; ID_EX_is_load = is_load;
    ID_rs1 = 5'd5; ID_rs1_used = 1'b1;
  endtask

  initial begin
    clr();
    exp_sc = '0;
    exp_bc = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset dominates busy, branch and hazard inputs.
    cur = "rst";
    mem_busy = 1'b1; ID_br_sel = BR_TAKE; ld_x5_in_ex(1'b1);
    run_c(); run_c();
    rst = 1'b0; clr();

    cur = "idle";
    run_c(); run_c();

    // x0 never creates a hazard.
    cur = "rd0";
    ID_EX_wr_en = 1'b1; ID_EX_is_load = 1'b1; EX_MEM_wr_en = 1'b1;
    ID_rs1_used = 1'b1; ID_rs2_used = 1'b1;
    run_c();

    // Unused sources and non-writing producers never match.
    cur = "unused";
    clr(); ld_x5_in_ex(1'b1); ID_rs1_used = 1'b0; ID_rs2 = 5'd5;
    run_c();
    cur = "nowr";
    clr(); ld_x5_in_ex(1'b1); ID_EX_wr_en = 1'b0;
    run_c();

    // Load-use on x5: producer moves from EX into MEM on the next cycle.
    cur = "load_use";
    clr(); ld_x5_in_ex(1'b1);
    haz_c();
    clr(); ID_rs1 = 5'd5; ID_rs1_used = 1'b1; EX_MEM_rd = 5'd5; EX_MEM_wr_en = 1'b1;
`ifdef HAZARD_FWD_EN
    run_c();
`else
    haz_c();
`endif
    clr(); run_c();

    // ALU op to x7 read through rs2.
    cur = "alu_use";
    ID_EX_rd = 5'd7; ID_EX_wr_en = 1'b1; ID_rs2 = 5'd7; ID_rs2_used = 1'b1;
`ifdef HAZARD_FWD_EN
    run_c();
`else
    haz_c();
`endif
    ID_EX_rd = '0; ID_EX_wr_en = 1'b0; EX_MEM_rd = 5'd7; EX_MEM_wr_en = 1'b1;
`ifdef HAZARD_FWD_EN
    run_c();
`else
    haz_c();
`endif
    clr(); run_c();

    // Branch: exactly BRP stall cycles, hazard inputs ignored while waiting.
    cur = "branch";
    ID_br_sel = BR_TAKE;
    br_c();
    ld_x5_in_ex(1'b1);
    br_c(); br_c();
    clr(); run_c();
    cur = "post_br";
    ld_x5_in_ex(1'b1);
    haz_c();
    clr();

    // Load-use hazard coinciding with a branch delays the penalty start.
    cur = "ld_br";
    ID_br_sel = BR_TAKE; ld_x5_in_ex(1'b1);
    haz_c();
    ID_EX_rd = '0; ID_EX_wr_en = 1'b0; ID_EX_is_load = 1'b0;
    EX_MEM_rd = 5'd5; EX_MEM_wr_en = 1'b1;
`ifndef HAZARD_FWD_EN
    haz_c();
    EX_MEM_wr_en = 1'b0;
`endif
    br_c();
    clr();
    br_c(); br_c();
    run_c();

    // Memory busy freezes a branch stall; reset right after release.
    cur = "busy_br";
    ID_br_sel = BR_TAKE;
    br_c();
    clr(); mem_busy = 1'b1;
    repeat (4) busy_c();
    mem_busy = 1'b0;
    br_c();
    rst = 1'b1;
    run_c();
    rst = 1'b0;
    cur = "after_rst";
    run_c();
    ID_br_sel = BR_TAKE;
    br_c();
    clr();
    br_c(); br_c();
    run_c();

    // Busy outranks both hazard and branch in RUN.
    cur = "busy_run";
    mem_busy = 1'b1; ID_br_sel = BR_TAKE; ld_x5_in_ex(1'b1);
    busy_c(); busy_c();
    clr(); run_c();

    // Counters saturate at all-ones.
    cur = "sat_sc";
    ld_x5_in_ex(1'b1);
    repeat (18) haz_c();
    clr(); run_c();
    cur = "sat_bc";
    ID_br_sel = BR_TAKE;
    repeat (18) br_c();
    clr(); run_c(); run_c();

    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("sat_sc_final", 32'(ST_stall_cycles), 32'd15);
    chk("sat_bc_final", 32'(ST_br_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
